axi_aw_rr_scheduler: RTL and testbench

- Write-address arbiter for one master port of the AXI node. Shares the master AW channel between N_TARG_PORT slave ports using round-robin arbitration.
- On every AW handshake it pushes the winner's {BIN_ID, OH_ID} into the write-data allocator's ID FIFO. This sequences which slave port's W beats are multiplexed next.
- It sits beside the write-data allocator in each master-side block. It owns the allocator's push_ID_i/ID_i/grant_FIFO_ID_o interface.

---
 rtl/axi_aw_rr_scheduler.sv | 149 ++++++++++++++
 tb/tb_axi_aw_rr_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_aw_rr_scheduler.sv
// -----------------------------------------------------------------------------
// axi_aw_rr_scheduler
//
// Round-robin arbiter for the AW channel of one master port of the AXI node.
// N_TARG_PORT slave ports compete for the master AW channel. Every completed
// AW handshake pushes the winner's {BIN_ID, OH_ID} into the write-data
// allocator's ID FIFO. That FIFO decides which slave port's W beats are
// multiplexed next.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   awvalid_i         per-port AW valid
//   awready_o         per-port AW ready (one-hot, only in a push cycle)
//   aw_payload_i      per-port packed AW payload (opaque)
//   awvalid_o         master-side AW valid
//   awready_i         master-side AW ready
//   aw_payload_o      payload of the selected port
//   push_ID_o         push strobe into the allocator's ID FIFO
//   ID_o              {binary index, one-hot index} of the selected port
//   grant_FIFO_ID_i   ID FIFO has free space
// -----------------------------------------------------------------------------
module axi_aw_rr_scheduler #(
  parameter int N_TARG_PORT  = 7,
  parameter int LOG_N_TARG   = $clog2(N_TARG_PORT),
  parameter int AW_PAYLOAD_W = 64
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [N_TARG_PORT-1:0]                  awvalid_i,
  output logic [N_TARG_PORT-1:0]                  awready_o,
  input  logic [N_TARG_PORT-1:0][AW_PAYLOAD_W-1:0] aw_payload_i,
  output logic                                    awvalid_o,
  input  logic                                    awready_i,
  output logic [AW_PAYLOAD_W-1:0]                 aw_payload_o,
  output logic                                    push_ID_o,
  output logic [LOG_N_TARG+N_TARG_PORT-1:0]       ID_o,
  input  logic                                    grant_FIFO_ID_i
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic [LOG_N_TARG-1:0] LAST_IDX = LOG_N_TARG'(N_TARG_PORT - 1);

  state_e                state_q, state_d;
  logic [LOG_N_TARG-1:0] rr_ptr_q, rr_ptr_d;
  logic [LOG_N_TARG-1:0] lock_idx_q, lock_idx_d;
  logic [LOG_N_TARG-1:0] winner;
  logic [LOG_N_TARG-1:0] sel;
  logic                  found;

  function automatic logic [N_TARG_PORT-1:0] onehot(input logic [LOG_N_TARG-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Increment with explicit wrap so a non power-of-2 port count never
  // produces an index >= N_TARG_PORT.
  function automatic logic [LOG_N_TARG-1:0] next_idx(input logic [LOG_N_TARG-1:0] idx);
    next_idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  // First asserted request scanning upward from rr_ptr, wrapping at N-1.
  always_comb begin : rr_scan
    int idx;
    winner = rr_ptr_q;
    found  = 1'b0;
    for (int off = 0; off < N_TARG_PORT; off++) begin
      idx = int'(rr_ptr_q) + off;
      if (idx >= N_TARG_PORT) idx = idx - N_TARG_PORT;
      if (!found && awvalid_i[idx]) begin
        found  = 1'b1;
        winner = LOG_N_TARG'(idx);
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin : fsm_comb
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    sel        = rr_ptr_q;
    awvalid_o  = 1'b0;
    awready_o  = '0;
    push_ID_o  = 1'b0;

    case (state_q)
      IDLE: begin
        // The FIFO-space check happens only here, on entry to a grant; a
        // grant that stalls is then guaranteed a slot when it completes.
        if (found && grant_FIFO_ID_i) begin
          sel       = winner;
          awvalid_o = 1'b1;
          if (awready_i) begin
            awready_o = onehot(winner);
            push_ID_o = 1'b1;
            rr_ptr_d  = next_idx(winner);
          end else begin
            lock_idx_d = winner;
            state_d    = LOCKED;
          end
        end
      end
      LOCKED: begin
        // Valid and payload stay pinned to the locked port until accepted;
        // other requesters are ignored meanwhile.
        sel       = lock_idx_q;
        awvalid_o = 1'b1;
        if (awready_i) begin
          awready_o = onehot(lock_idx_q);
          push_ID_o = 1'b1;
          rr_ptr_d  = next_idx(lock_idx_q);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake outputs are quiet for as long as reset is held, not just
    // from the next edge.
    if (!rst_n) begin
      awvalid_o = 1'b0;
      awready_o = '0;
      push_ID_o = 1'b0;
    end
  end

  assign aw_payload_o = aw_payload_i[sel];
  assign ID_o         = {sel, onehot(sel)};

  // NOTE: state registers take non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: tb/tb_axi_aw_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_axi_aw_rr_scheduler
//
// Two instances of the scheduler: a 3-port one driven by directed steps and a
// 5-port one driven by randomized AXI-legal requesters, a model of the ID
// FIFO, and a behavioural round-robin reference model.
// -----------------------------------------------------------------------------
module tb_axi_aw_rr_scheduler;

  localparam int PW         = 64;
  localparam int N3         = 3;
  localparam int L3         = $clog2(N3);
  localparam int N5         = 5;
  localparam int L5         = $clog2(N5);
  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // 3-port instance
  logic [N3-1:0]         v3, rdy3;
  logic [N3-1:0][PW-1:0] pl3;
  logic                  ov3, ir3, push3, fok3;
  logic [PW-1:0]         opl3;
  logic [L3+N3-1:0]      id3;

  // 5-port instance
  logic [N5-1:0]         v5, rdy5;
  logic [N5-1:0][PW-1:0] pl5;
  logic                  ov5, ir5, push5, fok5;
  logic [PW-1:0]         opl5;
  logic [L5+N5-1:0]      id5;

  axi_aw_rr_scheduler #(.N_TARG_PORT(N3), .AW_PAYLOAD_W(PW)) u_dut3 (
    .clk             (clk),
    .rst_n           (rst_n),
    .awvalid_i       (v3),
    .awready_o       (rdy3),
    .aw_payload_i    (pl3),
    .awvalid_o       (ov3),
    .awready_i       (ir3),
    .aw_payload_o    (opl3),
    .push_ID_o       (push3),
    .ID_o            (id3),
    .grant_FIFO_ID_i (fok3)
  );

  axi_aw_rr_scheduler #(.N_TARG_PORT(N5), .AW_PAYLOAD_W(PW)) u_dut5 (
    .clk             (clk),
    .rst_n           (rst_n),
    .awvalid_i       (v5),
    .awready_o       (rdy5),
    .aw_payload_i    (pl5),
    .awvalid_o       (ov5),
    .awready_i       (ir5),
    .aw_payload_o    (opl5),
    .push_ID_o       (push5),
    .ID_o            (id5),
    .grant_FIFO_ID_i (fok5)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One directed cycle on the 3-port instance. gi = granted port (-1: no
  // push this cycle), epi = port whose payload must be on the output (-1:
  // payload not checked).
  task automatic look3(input string tag, input logic ev, input int gi, input int epi);
    logic [N3-1:0]    erdy;
    logic [L3+N3-1:0] eid;
    erdy = '0;
    eid  = '0;
    if (gi >= 0) begin
      erdy     = N3'(1) << gi;
      eid      = {L3'(gi), erdy};
    end
    @(negedge clk);
    check({tag, ".valid"}, 128'(ov3), 128'(ev));
    check({tag, ".ready"}, 128'(rdy3), 128'(erdy));
    check({tag, ".push"}, 128'(push3), 128'(gi >= 0));
    if (gi >= 0) check({tag, ".id"}, 128'(id3), 128'(eid));
    if (epi >= 0) check({tag, ".payload"}, 128'(opl3), 128'(pl3[epi]));
    @(posedge clk);
    #1;
  endtask

  // Reference model for the 5-port instance: round-robin order expressed
  // with modulo arithmetic, plus "which port is stalled mid-handshake".
  int                 m_rr5   = 0;
  int                 m_lock5 = -1;
  logic [N5-1:0]      pend5   = '0;
  logic [L5+N5-1:0]   fifo_q[$];
  int                 gcnt[N5];
  logic               prev_v5  = 1'b0;
  logic               prev_hs5 = 1'b0;
  logic [PW-1:0]      prev_pl5 = '0;

  function automatic int rr_pick(input logic [N5-1:0] req, input int start);
    for (int k = 0; k < N5; k++) begin
      if (req[(start + k) % N5]) return (start + k) % N5;
    end
    return -1;
  endfunction

  task automatic run5(input int cycles, input bit full_load);
    logic             exp_v, exp_push;
    int               exp_idx;
    logic [N5-1:0]    exp_rdy;
    logic [L5+N5-1:0] exp_id;
    for (int c = 0; c < cycles; c++) begin
      // Requesters: a raised request holds valid and payload until accepted.
      for (int p = 0; p < N5; p++) begin
        if (!pend5[p] && (full_load || $urandom_range(0, 3) == 0)) begin
          pend5[p] = 1'b1;
          pl5[p]   = {$urandom, $urandom};
        end
      end
      v5   = pend5;
      ir5  = full_load ? 1'b1 : ($urandom_range(0, 2) != 0);
      fok5 = (fifo_q.size() < FIFO_DEPTH);

      @(negedge clk);
      exp_v   = 1'b0;
      exp_idx = m_rr5;
      if (m_lock5 >= 0) begin
        exp_v   = 1'b1;
        exp_idx = m_lock5;
      end else if (fok5 && pend5 != '0) begin
        exp_v   = 1'b1;
        exp_idx = rr_pick(pend5, m_rr5);
      end
      exp_push = exp_v && ir5;
      exp_rdy  = exp_push ? (N5'(1) << exp_idx) : '0;
      exp_id   = {L5'(exp_idx), N5'(1) << exp_idx};

      check("r5.valid", 128'(ov5), 128'(exp_v));
      check("r5.ready", 128'(rdy5), 128'(exp_rdy));
      check("r5.push", 128'(push5), 128'(exp_push));
      check("r5.payload", 128'(opl5), 128'(pl5[exp_idx]));
      if (exp_push) check("r5.id", 128'(id5), 128'(exp_id));
      check("r5.push_while_full", 128'(push5 && !fok5), 128'(0));
      if (prev_v5 && !prev_hs5) check("r5.valid_hold", {63'd0, ov5, opl5}, {63'd0, 1'b1, prev_pl5});

      for (int p = 0; p < N5; p++) if (rdy5[p]) gcnt[p]++;
      prev_v5  = ov5;
      prev_hs5 = ov5 && ir5;
      prev_pl5 = opl5;

      if (exp_push) begin
        pend5[exp_idx] = 1'b0;
        m_rr5          = (exp_idx + 1) % N5;
        m_lock5        = -1;
        fifo_q.push_back(exp_id);
      end else if (exp_v) begin
        m_lock5 = exp_idx;
      end
      if (fifo_q.size() > 0 && (full_load || $urandom_range(0, 1) == 0)) void'(fifo_q.pop_front());

      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int gmin, gmax;

    rst_n = 1'b0;
    for (int i = 0; i < N3; i++) pl3[i] = 64'(i + 1) * 64'h0101_0101_0101_0101;
    for (int i = 0; i < N5; i++) pl5[i] = '0;
    v3 = '1; ir3 = 1'b1; fok3 = 1'b1;
    v5 = '1; ir5 = 1'b1; fok5 = 1'b1;

    // Reset: handshake outputs quiet even with requests pending.
    #3;
    check("rst.valid3", 128'(ov3), 128'(0));
    check("rst.ready3", 128'(rdy3), 128'(0));
    check("rst.push3", 128'(push3), 128'(0));
    check("rst.valid5", 128'(ov5), 128'(0));
    check("rst.ready5", 128'(rdy5), 128'(0));
    check("rst.push5", 128'(push5), 128'(0));
    v3 = '0;
    v5 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All ports requesting, always ready: one grant per cycle in order.
    v3 = 3'b111;
    for (int i = 0; i < 6; i++) look3("t1.b2b", 1'b1, i % 3, i % 3);

    // Stall on port 1; a new request from port 0 must not steal the lock.
    v3 = 3'b010; ir3 = 1'b0;
    look3("t2.stall", 1'b1, -1, 1);
    v3 = 3'b011;
    for (int i = 0; i < 3; i++) look3("t2.stall", 1'b1, -1, 1);
    ir3 = 1'b1;
    look3("t2.accept", 1'b1, 1, 1);

    // rr_ptr is now 2: ports 0,1 requesting wraps to 0, then 1.
    v3 = 3'b011;
    look3("t4.wrap", 1'b1, 0, 0);
    look3("t4.next", 1'b1, 1, 1);

    // Bring rr_ptr back to 0, then block on a full FIFO.
    v3 = 3'b100;
    look3("t3.prep", 1'b1, 2, 2);
    fok3 = 1'b0; v3 = 3'b101;
    look3("t3.full", 1'b0, -1, 0);
    fok3 = 1'b1;
    look3("t3.space", 1'b1, 0, 0);

    // Lock on port 2, then reset mid-transaction.
    v3 = 3'b100; ir3 = 1'b0;
    look3("t5.lock", 1'b1, -1, 2);
    rst_n = 1'b0;
    look3("t5.reset", 1'b0, -1, -1);
    rst_n = 1'b1;
    v3 = 3'b101; ir3 = 1'b1;
    look3("t5.fresh0", 1'b1, 0, 0);
    v3 = 3'b100;
    look3("t5.fresh2", 1'b1, 2, 2);
    v3 = '0;

    // Randomized traffic with FIFO back-pressure on the 5-port instance.
    run5(4000, 1'b0);

    // Saturated load: grant counts must stay within one of each other.
    fifo_q.delete();
    for (int p = 0; p < N5; p++) gcnt[p] = 0;
    run5(50, 1'b1);
    gmin = gcnt[0];
    gmax = gcnt[0];
    for (int p = 1; p < N5; p++) begin
      if (gcnt[p] < gmin) gmin = gcnt[p];
      if (gcnt[p] > gmax) gmax = gcnt[p];
    end
    check("r5.fair_spread", 128'(gmax - gmin <= 1), 128'(1));
    check("r5.fair_total", 128'(gcnt[0] + gcnt[1] + gcnt[2] + gcnt[3] + gcnt[4]), 128'(50));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
